// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MIPS memory-access stage.
// The EX->MEM bus layout is captured once here as a packed struct.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int MS_TO_WS_BUS_WD = 70;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic [1:0]  addr_low;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a load word and sign/zero-extends it.
// Unknown type codes behave as a full-word load.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_low)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'd0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds one EX instruction, waits for its load data,
// and forwards the aligned result to WB and to the hazard logic.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_write_reg,
    output logic [4:0]                 ms_reg_dest,
    output logic                       ms_fwd_ok,
    output logic [31:0]                ms_fwd_data,
    output logic                       ms_ld_pending
);

    logic        ms_valid_q, ms_valid_d;
    es_bus_t     es_bus_q, es_bus_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic        ms_ready_go;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_ready_go    = !es_bus_q.res_from_mem || buf_valid_q || data_sram_data_ok;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    assign load_src = buf_valid_q ? buf_data_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .ld_type  (es_bus_q.ld_type),
        .addr_low (es_bus_q.addr_low),
        .rdata    (load_src),
        .result   (load_data)
    );

    assign final_result = es_bus_q.res_from_mem ? load_data : es_bus_q.alu_result;
    assign ms_to_ws_bus = {es_bus_q.gr_we, es_bus_q.dest, final_result, es_bus_q.pc};

    assign ms_write_reg  = ms_valid_q && es_bus_q.gr_we;
    assign ms_reg_dest   = es_bus_q.dest;
    assign ms_ld_pending = ms_valid_q && es_bus_q.res_from_mem && !ms_ready_go;
    assign ms_fwd_ok     = ms_valid_q && es_bus_q.gr_we && ms_ready_go;
    assign ms_fwd_data   = final_result;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        es_bus_d    = es_bus_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_d = es_bus_t'(es_to_ms_bus);
        end
        // Only hold the response when WB is blocked; otherwise it flows straight through.
        if (ms_to_ws_valid && ws_allowin) begin
            buf_valid_d = 1'b0;
            buf_data_d  = 32'd0;
        end else if (data_sram_data_ok && ms_valid_q && es_bus_q.res_from_mem
                     && !buf_valid_q && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            es_bus_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'd0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            es_bus_q    <= es_bus_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage and its load-align sub-module.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_write_reg;
    logic [4:0]  ms_reg_dest;
    logic        ms_fwd_ok;
    logic [31:0] ms_fwd_data;
    logic        ms_ld_pending;

    logic [2:0]  al_type;
    logic [1:0]  al_addr;
    logic [31:0] al_rdata;
    logic [31:0] al_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_write_reg      (ms_write_reg),
        .ms_reg_dest       (ms_reg_dest),
        .ms_fwd_ok         (ms_fwd_ok),
        .ms_fwd_data       (ms_fwd_data),
        .ms_ld_pending     (ms_ld_pending)
    );

    mem_stage_load_align u_align (
        .ld_type  (al_type),
        .addr_low (al_addr),
        .rdata    (al_rdata),
        .result   (al_result)
    );

    typedef struct {
        logic [2:0]  t;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] r;
    } align_vec_t;

    align_vec_t avec[10] = '{
        '{3'd0, 2'd1, 32'h89ABCDEF, 32'h89ABCDEF},
        '{3'd1, 2'd0, 32'h89ABCDEF, 32'hFFFFFFEF},
        '{3'd1, 2'd1, 32'h89ABCDEF, 32'hFFFFFFCD},
        '{3'd1, 2'd2, 32'h89ABCDEF, 32'hFFFFFFAB},
        '{3'd2, 2'd3, 32'h89ABCDEF, 32'h00000089},
        '{3'd3, 2'd0, 32'h89ABCDEF, 32'hFFFFCDEF},
        '{3'd3, 2'd2, 32'h89ABCDEF, 32'hFFFF89AB},
        '{3'd4, 2'd2, 32'h89ABCDEF, 32'h000089AB},
        '{3'd5, 2'd3, 32'h89ABCDEF, 32'h89ABCDEF},
        '{3'd1, 2'd0, 32'h0000007F, 32'h0000007F}
    };

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [75:0] mk_bus(input logic [2:0] t, input logic [1:0] a,
                                           input logic rfm, input logic we, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {t, a, rfm, we, dst, alu, pc};
    endfunction

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        al_type = '0;
        al_addr = '0;
        al_rdata = '0;

        foreach (avec[i]) begin
            al_type  = avec[i].t;
            al_addr  = avec[i].a;
            al_rdata = avec[i].d;
            #1;
            chk($sformatf("align%0d", i), al_result, avec[i].r);
        end

        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_wreg", ms_write_reg, 1'b0);
        chk("rst_pend", ms_ld_pending, 1'b0);
        chk("rst_fwd", ms_fwd_ok, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);

        // ALU op passes in one cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hBFC00000);
        tick();
        es_to_ms_valid = 1'b0;
        chk("alu_valid", ms_to_ws_valid, 1'b1);
        chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h00001234, 32'hBFC00000});
        chk("alu_fwd", ms_fwd_ok, 1'b1);
        chk("alu_fwd_data", ms_fwd_data, 32'h1234);
        chk("alu_wreg", ms_write_reg, 1'b1);
        chk("alu_dest", ms_reg_dest, 5'd5);
        tick();
        chk("alu_gone", ms_to_ws_valid, 1'b0);

        // LB waits three cycles for data
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd1, 2'd2, 1'b1, 1'b1, 5'd7, 32'h100, 32'hBFC00010);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_pend%0d", i), ms_ld_pending, 1'b1);
            chk($sformatf("lb_wait%0d", i), ms_to_ws_valid, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11802233;
        #1;
        chk("lb_valid", ms_to_ws_valid, 1'b1);
        chk("lb_pend_end", ms_ld_pending, 1'b0);
        chk("lb_result", ms_to_ws_bus[63:32], 32'hFFFFFF80);
        chk("lb_fwd", ms_fwd_ok, 1'b1);
        chk("lb_allowin", ms_allowin, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        chk("lb_gone", ms_to_ws_valid, 1'b0);

        // LHU response lands while WB is blocked
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd4, 2'd2, 1'b1, 1'b1, 5'd9, 32'h200, 32'hBFC00020);
        tick();
        es_to_ms_valid = 1'b0;
        chk("lhu_pend", ms_ld_pending, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h8001FFFF;
        #1;
        chk("lhu_ready", ms_to_ws_valid, 1'b1);
        chk("lhu_blocked", ms_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        #1;
        chk("lhu_buf_valid", ms_to_ws_valid, 1'b1);
        chk("lhu_buf_res", ms_to_ws_bus[63:32], 32'h00008001);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h12345678;
        #1;
        chk("lhu_late_ok", ms_fwd_data, 32'h00008001);
        tick();
        data_sram_data_ok = 1'b0;
        ws_allowin = 1'b1;
        #1;
        chk("lhu_exit_valid", ms_to_ws_valid, 1'b1);
        chk("lhu_exit_res", ms_to_ws_bus[63:32], 32'h00008001);
        chk("lhu_exit_allow", ms_allowin, 1'b1);
        tick();
        chk("lhu_gone", ms_to_ws_valid, 1'b0);

        // Back-to-back ALU ops at full throughput
        es_to_ms_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'(i + 1), 32'h100 + i, 32'hBFC00100 + 4 * i);
            tick();
            chk($sformatf("b2b_valid%0d", i), ms_to_ws_valid, 1'b1);
            chk($sformatf("b2b_res%0d", i), ms_to_ws_bus[63:32], 32'h100 + i);
            chk($sformatf("b2b_allow%0d", i), ms_allowin, 1'b1);
        end
        ws_allowin = 1'b0;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd20, 32'h200, 32'hBFC00200);
        #1;
        chk("stall_allow", ms_allowin, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("stall_bus%0d", i), ms_to_ws_bus, {1'b1, 5'd4, 32'h103, 32'hBFC0010C});
            chk($sformatf("stall_allow%0d", i), ms_allowin, 1'b0);
        end
        ws_allowin = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        chk("resume_bus", ms_to_ws_bus, {1'b1, 5'd20, 32'h200, 32'hBFC00200});
        tick();
        chk("resume_gone", ms_to_ws_valid, 1'b0);

        // Reset abandons a waiting load; stray response is dropped
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd3, 32'h300, 32'hBFC00300);
        tick();
        es_to_ms_valid = 1'b0;
        chk("rl_pend", ms_ld_pending, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rl_valid", ms_to_ws_valid, 1'b0);
        chk("rl_pend_clr", ms_ld_pending, 1'b0);
        chk("rl_wreg", ms_write_reg, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFEF00D;
        #1;
        chk("rl_stray", ms_to_ws_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        chk("rl_after", ms_to_ws_valid, 1'b0);

        // Store passes without data_ok
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b0, 1'b0, 5'd0, 32'h40, 32'hBFC00400);
        tick();
        es_to_ms_valid = 1'b0;
        chk("st_valid", ms_to_ws_valid, 1'b1);
        chk("st_wreg", ms_write_reg, 1'b0);
        chk("st_fwd", ms_fwd_ok, 1'b0);
        chk("st_pend", ms_ld_pending, 1'b0);
        chk("st_bus", ms_to_ws_bus, {1'b0, 5'd0, 32'h40, 32'hBFC00400});
        tick();
        chk("st_gone", ms_to_ws_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory-access stage, between execute (EX) and write-back (WB).
- Latches the EX bus and waits for the data-SRAM response of an in-flight load.
- Extracts and sign/zero-extends load data and forwards the result bus to WB.
- Exports its destination/result to the hazard logic for stall and forwarding decisions.

Parameters:
- ES_TO_MS_BUS_WD, 76: EX->MEM bus width (shared header constant).
- MS_TO_WS_BUS_WD, 70: MEM->WB bus width (shared header constant).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  76  {ld_type[75:73], addr_low[72:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- ms_allowin  out  1  MEM can accept from EX
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  valid result for WB
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- data_sram_data_ok  in  1  load response strobe, one cycle
- data_sram_rdata  in  32  load response data
- ms_write_reg  out  1  valid instruction in MEM writes a GPR
- ms_reg_dest  out  5  its destination
- ms_fwd_ok  out  1  ms_final_result is usable for forwarding
- ms_fwd_data  out  32  forwarded result
- ms_ld_pending  out  1  valid load still waiting for data; ID must stall a dependent instruction

Behaviour:
- Registers:
  - ms_valid: reset 0.
  - bus register: reset 0.
  - data buffer (buf_valid, buf_data): reset 0.
- Reset values: all outputs derive from these registers, so after reset ms_to_ws_valid=0, ms_write_reg=0, ms_ld_pending=0, ms_fwd_ok=0, ms_allowin=1.
- Handshake:
  - ms_ready_go = !res_from_mem | buf_valid | data_sram_data_ok.
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- Latch:
  - If ms_allowin: ms_valid <= es_to_ms_valid.
  - If es_to_ms_valid & ms_allowin: bus register <= es_to_ms_bus.
- Outstanding requests: at most one, owned by the load currently in MEM. EX does not issue a new load request while MEM's ms_ld_pending=1.
- Data buffer:
  - Set: data_sram_data_ok & ms_valid & res_from_mem & !buf_valid & !ws_allowin. Captures rdata.
  - Clear: when the instruction leaves MEM (ms_to_ws_valid & ws_allowin), or on reset.
- Latency:
  - Non-load: 1 cycle in MEM when WB allows.
  - Load: exits the same cycle data_ok arrives. Data is combinationally selected as buf_valid ? buf_data : data_sram_rdata.
- data_ok while !ms_valid or !res_from_mem: dropped, with no state change. This covers a stale response after reset mid-load.
- Load extraction, with d = selected data and a = addr_low:
  - 0 LW: d.
  - 1 LB: sign-extend byte a.
  - 2 LBU: zero-extend byte a.
  - 3 LH: sign-extend half a[1].
  - 4 LHU: zero-extend half a[1].
  - Codes 5-7: treat as LW.
- final_result = res_from_mem ? load_data : alu_result.
- Hazard outputs:
  - ms_write_reg = ms_valid & gr_we.
  - ms_reg_dest = dest.
  - ms_ld_pending = ms_valid & res_from_mem & !ms_ready_go.
  - ms_fwd_ok = ms_valid & gr_we & ms_ready_go.
  - ms_fwd_data = final_result.
- Simultaneous events: leave and accept in the same cycle are allowed (full throughput). data_ok with ws_allowin=1 passes straight through, with no buffering.
- Reset mid-operation: valid and buffer clear next edge. The pending load is abandoned.

Decomposition:
- Shared header: ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, and the LD_* type codes (LW=0, LB=1, LBU=2, LH=3, LHU=4).
- One combinational sub-module: load_align (ld_type, addr_low, rdata -> 32-bit result). Unit-test it separately.

Test Plan:
- ALU op, gr_we=1, dest=5, alu_result=0x1234, pc=0xBFC00000, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x00001234,0xBFC00000}, ms_fwd_ok=1.
- LB, addr_low=2, data_ok 3 cycles after latch with rdata=0x11802233 -> ms_ld_pending=1 for 3 cycles; then final_result=0xFFFFFF80, valid same cycle as data_ok.
- LHU, addr_low=2, rdata=0x8001FFFF, data_ok while ws_allowin=0 -> buffer captures; when ws_allowin rises, final_result=0x00008001. A later data_ok pulse is ignored.
- Back-to-back ALU ops, ws_allowin held 1 -> one instruction exits per cycle, ms_allowin stays 1. Drop ws_allowin for 2 cycles -> held instruction and bus stable, ms_allowin=0.
- Reset asserted while a load waits -> ms_valid=0, ms_ld_pending=0. Stray data_ok next cycle -> no ms_to_ws_valid.
- Store (gr_we=0) -> ms_write_reg=0, ms_fwd_ok=0, passes in 1 cycle without waiting for data_ok.
